// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared memtoreg and forward-select encodings for the hazard scoreboard
package hazard_pkg;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;
    localparam logic [1:0] M2R_NONE = 2'b11;

    localparam logic [2:0] FWD_NONE   = 3'b000;
    localparam logic [2:0] FWD_EX_ALU = 3'b001;
    localparam logic [2:0] FWD_EX_PC4 = 3'b010;
    localparam logic [2:0] FWD_WB_ALU = 3'b011;
    localparam logic [2:0] FWD_WB_MEM = 3'b100;
    localparam logic [2:0] FWD_WB_PC4 = 3'b101;

    // A load in EX/MEM has no data yet, so it maps to no forward (the caller stalls instead).
    function automatic logic [2:0] ex_fwd_code(input logic [1:0] m2r);
        case (m2r)
            M2R_ALU: ex_fwd_code = FWD_EX_ALU;
            M2R_PC4: ex_fwd_code = FWD_EX_PC4;
            default: ex_fwd_code = FWD_NONE;
        endcase
    endfunction

    function automatic logic [2:0] wb_fwd_code(input logic [1:0] m2r);
        case (m2r)
            M2R_ALU: wb_fwd_code = FWD_WB_ALU;
            M2R_MEM: wb_fwd_code = FWD_WB_MEM;
            M2R_PC4: wb_fwd_code = FWD_WB_PC4;
            default: wb_fwd_code = FWD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - forward select, load-use and busy-RAW detection for one source operand
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic [REG_AW-1:0]   rs_addr,
    input  logic                rs_used,
    input  logic                ex_wr_en,
    input  logic [REG_AW-1:0]   ex_wr_addr,
    input  logic [1:0]          ex_m2r,
    input  logic                wb_wr_en,
    input  logic [REG_AW-1:0]   wb_wr_addr,
    input  logic [1:0]          wb_m2r,
    input  logic [NUM_REGS-1:0] busy_vec,
    output logic [2:0]          fwd_sel,
    output logic                load_use,
    output logic                raw_busy
);

    // The youngest producer (EX/MEM) shadows MEM/WB; x0 and unused operands never match.
    always_comb begin
        fwd_sel  = FWD_NONE;
        load_use = 1'b0;
        raw_busy = 1'b0;
        if (rs_used && (rs_addr != '0)) begin
            raw_busy = busy_vec[rs_addr];
            if (ex_wr_en && (ex_wr_addr == rs_addr)) begin
                fwd_sel  = ex_fwd_code(ex_m2r);
                load_use = (ex_m2r == M2R_MEM);
            end else if (wb_wr_en && (wb_wr_addr == rs_addr)) begin
                fwd_sel  = wb_fwd_code(wb_m2r);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding, stall and mul/div busy scoreboard (option: HAZARD_PERF_CNT_EN)
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter  int NUM_RD_PORTS = 2,
    parameter  int NUM_REGS     = 32,
    localparam int REG_AW       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] rs_addr,
    input  logic [NUM_RD_PORTS-1:0]        rs_used,
    input  logic                           ex_wr_en,
    input  logic [REG_AW-1:0]              ex_wr_addr,
    input  logic [1:0]                     ex_m2r,
    input  logic                           wb_wr_en,
    input  logic [REG_AW-1:0]              wb_wr_addr,
    input  logic [1:0]                     wb_m2r,
    input  logic                           id_wr_en,
    input  logic [REG_AW-1:0]              id_wr_addr,
    input  logic                           md_issue,
    input  logic [REG_AW-1:0]              md_issue_rd,
    input  logic                           md_done,
    input  logic [REG_AW-1:0]              md_done_rd,
    output logic [NUM_RD_PORTS*3-1:0]      fwd_sel,
    output logic                           stall,
    output logic                           sb_err,
    output logic [NUM_REGS-1:0]            busy_vec
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [31:0]                    lu_stall_cnt
`endif
);

    logic [NUM_REGS-1:0]     busy_q;
    logic [NUM_REGS-1:0]     busy_nxt;
    logic                    err_nxt;
    logic [NUM_RD_PORTS-1:0] load_use_vec;
    logic [NUM_RD_PORTS-1:0] raw_vec;
    logic                    waw;
    logic                    load_use_any;

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port
        fwd_port_sel #(
            .NUM_REGS (NUM_REGS)
        ) u_fwd_port_sel (
            .rs_addr    (rs_addr[i*REG_AW +: REG_AW]),
            .rs_used    (rs_used[i]),
            .ex_wr_en   (ex_wr_en),
            .ex_wr_addr (ex_wr_addr),
            .ex_m2r     (ex_m2r),
            .wb_wr_en   (wb_wr_en),
            .wb_wr_addr (wb_wr_addr),
            .wb_m2r     (wb_m2r),
            .busy_vec   (busy_q),
            .fwd_sel    (fwd_sel[i*3 +: 3]),
            .load_use   (load_use_vec[i]),
            .raw_busy   (raw_vec[i])
        );
    end

    // Stall on load-use, on reading a pending mul/div result, or on overwriting one (WAW).
    always_comb begin
        waw          = id_wr_en && (id_wr_addr != '0) && busy_q[id_wr_addr];
        load_use_any = |load_use_vec;
        stall        = load_use_any || (|raw_vec) || waw;
    end

    // Completion clears first so that a same-cycle issue to the same register keeps it busy.
    always_comb begin
        busy_nxt = busy_q;
        err_nxt  = sb_err;
        if (md_done) begin
            if (busy_q[md_done_rd]) begin
                busy_nxt[md_done_rd] = 1'b0;
            end else begin
                err_nxt = 1'b1;
            end
        end
        if (md_issue && (md_issue_rd != '0)) begin
            busy_nxt[md_issue_rd] = 1'b1;
        end
    end

    // Scoreboard state keeps updating regardless of stall; reset drops all in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            sb_err <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            sb_err <= err_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counts of all stall cycles and of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            lu_stall_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (load_use_any && (lu_stall_cnt != 32'hFFFF_FFFF)) begin
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

    localparam int NP = 2;
    localparam int NR = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NP*AW-1:0] rs_addr;
    logic [NP-1:0]  rs_used;
    logic           ex_wr_en, wb_wr_en, id_wr_en, md_issue, md_done;
    logic [AW-1:0]  ex_wr_addr, wb_wr_addr, id_wr_addr, md_issue_rd, md_done_rd;
    logic [1:0]     ex_m2r, wb_m2r;
    logic [NP*3-1:0] fwd_sel;
    logic           stall, sb_err;
    logic [NR-1:0]  busy_vec;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]    stall_cnt, lu_stall_cnt;
    int unsigned    m_stall_cnt, m_lu_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit [NR-1:0] m_busy;
    bit          m_err;

    hazard_scoreboard_unit #(.NUM_RD_PORTS(NP), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_used(rs_used),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_m2r(ex_m2r),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_m2r(wb_m2r),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_done(md_done), .md_done_rd(md_done_rd),
        .fwd_sel(fwd_sel), .stall(stall), .sb_err(sb_err), .busy_vec(busy_vec)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .lu_stall_cnt(lu_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a0, a1;
        logic [1:0]    used;
        logic          ex_en; logic [AW-1:0] ex_a; logic [1:0] ex_m;
        logic          wb_en; logic [AW-1:0] wb_a; logic [1:0] wb_m;
        logic          id_en; logic [AW-1:0] id_a;
        logic [2:0]    f0, f1;
        logic          st;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_addr = '0; rs_used = '0;
        ex_wr_en = 0; ex_wr_addr = '0; ex_m2r = 2'b00;
        wb_wr_en = 0; wb_wr_addr = '0; wb_m2r = 2'b00;
        id_wr_en = 0; id_wr_addr = '0;
        md_issue = 0; md_issue_rd = '0; md_done = 0; md_done_rd = '0;
    endtask

    // Reference: which stage (if any) supplies operand p, from the producer rules.
    function automatic logic [2:0] ref_sel(int p);
        logic [AW-1:0] a;
        a = rs_addr[p*AW +: AW];
        if (!rs_used[p] || a == 0) return 3'd0;
        if (ex_wr_en && ex_wr_addr == a) return (ex_m2r == 2'd0) ? 3'd1 : (ex_m2r == 2'd2) ? 3'd2 : 3'd0;
        if (wb_wr_en && wb_wr_addr == a)
            return (wb_m2r == 2'd0) ? 3'd3 : (wb_m2r == 2'd1) ? 3'd4 : (wb_m2r == 2'd2) ? 3'd5 : 3'd0;
        return 3'd0;
    endfunction

    function automatic bit ref_lu();
        for (int p = 0; p < NP; p++) begin
            logic [AW-1:0] a;
            a = rs_addr[p*AW +: AW];
            if (rs_used[p] && a != 0 && ex_wr_en && ex_wr_addr == a && ex_m2r == 2'd1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ref_stall();
        if (ref_lu()) return 1'b1;
        for (int p = 0; p < NP; p++) begin
            logic [AW-1:0] a;
            a = rs_addr[p*AW +: AW];
            if (rs_used[p] && a != 0 && m_busy[a]) return 1'b1;
        end
        return id_wr_en && id_wr_addr != 0 && m_busy[id_wr_addr];
    endfunction

    task automatic model_clock();
`ifdef HAZARD_PERF_CNT_EN
        if (ref_stall() && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (ref_lu() && m_lu_cnt != 32'hFFFF_FFFF) m_lu_cnt++;
`endif
        if (md_done) begin
            if (m_busy[md_done_rd]) m_busy[md_done_rd] = 1'b0;
            else m_err = 1'b1;
        end
        if (md_issue && md_issue_rd != 0) m_busy[md_issue_rd] = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_err  = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall_cnt = 0;
        m_lu_cnt    = 0;
`endif
    endtask

    // Caller drives inputs just after a negedge; returns at the next negedge.
    task automatic tick(input string tag);
        #1;
        for (int p = 0; p < NP; p++)
            check($sformatf("%s fwd%0d", tag, p), 64'(fwd_sel[p*3 +: 3]), 64'(ref_sel(p)));
        check({tag, " stall"}, 64'(stall), 64'(ref_stall()));
        @(posedge clk);
        model_clock();
        #1;
        check({tag, " busy_vec"}, 64'(busy_vec), 64'(m_busy));
        check({tag, " sb_err"}, 64'(sb_err), 64'(m_err));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall_cnt));
        check({tag, " lu_cnt"}, 64'(lu_stall_cnt), 64'(m_lu_cnt));
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check({tag, " rst busy_vec"}, 64'(busy_vec), 64'd0);
        check({tag, " rst sb_err"}, 64'(sb_err), 64'd0);
        check({tag, " rst stall"}, 64'(stall), 64'd0);
        check({tag, " rst fwd_sel"}, 64'(fwd_sel), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, " rst stall_cnt"}, 64'(stall_cnt), 64'd0);
        check({tag, " rst lu_cnt"}, 64'(lu_stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];
    logic exp_st[6];

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        do_reset("init");

        // Combinational vectors with an empty scoreboard; rows 1-2 are consecutive cycles.
        vecs.push_back('{5'd5, 5'd0, 2'b01, 1, 5'd5, 2'b00, 1, 5'd5, 2'b01, 0, 5'd0, 3'b001, 3'b000, 0});
        vecs.push_back('{5'd0, 5'd7, 2'b10, 1, 5'd7, 2'b01, 0, 5'd0, 2'b00, 0, 5'd0, 3'b000, 3'b000, 1});
        vecs.push_back('{5'd0, 5'd7, 2'b10, 0, 5'd0, 2'b00, 1, 5'd7, 2'b01, 0, 5'd0, 3'b000, 3'b100, 0});
        vecs.push_back('{5'd0, 5'd0, 2'b11, 1, 5'd0, 2'b00, 1, 5'd0, 2'b00, 0, 5'd0, 3'b000, 3'b000, 0});
        vecs.push_back('{5'd3, 5'd3, 2'b11, 1, 5'd3, 2'b10, 1, 5'd3, 2'b00, 0, 5'd0, 3'b010, 3'b010, 0});
        vecs.push_back('{5'd6, 5'd0, 2'b01, 0, 5'd6, 2'b00, 1, 5'd6, 2'b00, 0, 5'd0, 3'b011, 3'b000, 0});
        vecs.push_back('{5'd0, 5'd8, 2'b10, 0, 5'd0, 2'b00, 1, 5'd8, 2'b10, 0, 5'd0, 3'b000, 3'b101, 0});
        vecs.push_back('{5'd9, 5'd0, 2'b01, 0, 5'd0, 2'b00, 1, 5'd9, 2'b11, 0, 5'd0, 3'b000, 3'b000, 0});
        vecs.push_back('{5'd5, 5'd0, 2'b00, 1, 5'd5, 2'b01, 0, 5'd0, 2'b00, 0, 5'd0, 3'b000, 3'b000, 0});
        vecs.push_back('{5'd5, 5'd0, 2'b01, 0, 5'd5, 2'b01, 0, 5'd0, 2'b00, 1, 5'd5, 3'b000, 3'b000, 0});
        vecs.push_back('{5'd4, 5'd4, 2'b11, 1, 5'd4, 2'b11, 1, 5'd4, 2'b00, 0, 5'd0, 3'b000, 3'b000, 0});

        foreach (vecs[i]) begin
            rs_addr = {vecs[i].a1, vecs[i].a0}; rs_used = vecs[i].used;
            ex_wr_en = vecs[i].ex_en; ex_wr_addr = vecs[i].ex_a; ex_m2r = vecs[i].ex_m;
            wb_wr_en = vecs[i].wb_en; wb_wr_addr = vecs[i].wb_a; wb_m2r = vecs[i].wb_m;
            id_wr_en = vecs[i].id_en; id_wr_addr = vecs[i].id_a;
            #1;
            check($sformatf("vec%0d fwd0", i), 64'(fwd_sel[2:0]), 64'(vecs[i].f0));
            check($sformatf("vec%0d fwd1", i), 64'(fwd_sel[5:3]), 64'(vecs[i].f1));
            check($sformatf("vec%0d stall", i), 64'(stall), 64'(vecs[i].st));
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end

        // x0 never becomes busy.
        idle();
        md_issue = 1; md_issue_rd = 5'd0;
        tick("issue_x0");
        check("issue_x0 busy_vec zero", 64'(busy_vec), 64'd0);

        // Multi-cycle RAW: stall holds until the cycle after completion.
        idle();
        md_issue = 1; md_issue_rd = 5'd9;
        tick("md9_issue");
        check("md9 busy set", 64'(busy_vec[9]), 64'd1);
        exp_st = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            idle();
            rs_addr[4:0] = 5'd9; rs_used = 2'b01;
            md_done = (i == 3); md_done_rd = 5'd9;
            #1;
            check($sformatf("md9 stall c%0d", i), 64'(stall), 64'(exp_st[i]));
            tick("md9_read");
            check($sformatf("md9 busy c%0d", i), 64'(busy_vec[9]), (i >= 3) ? 64'd0 : 64'd1);
        end

        // Same-cycle issue and done keep the bit; done to an idle register is an error.
        idle();
        md_issue = 1; md_issue_rd = 5'd3;
        tick("md3_issue");
        md_done = 1; md_done_rd = 5'd3;
        tick("md3_both");
        check("md3 busy kept", 64'(busy_vec[3]), 64'd1);
        check("md3 no err", 64'(sb_err), 64'd0);
        idle();
        id_wr_en = 1; id_wr_addr = 5'd3;
        #1;
        check("waw stall", 64'(stall), 64'd1);
        md_done = 1; md_done_rd = 5'd4;
        tick("md4_spurious");
        check("md4 sb_err", 64'(sb_err), 64'd1);
        check("md4 busy unchanged", 64'(busy_vec), 64'(1 << 3));

        // Reset while rd12 is busy, then a late completion raises the error.
        do_reset("pre12");
        md_issue = 1; md_issue_rd = 5'd12;
        tick("md12_issue");
        idle();
        rs_addr[4:0] = 5'd12; rs_used = 2'b01;
        md_done = 1; md_done_rd = 5'd20;
        tick("md12_err");
        rst_n = 1'b0;
        #1;
        check("rst12 busy_vec", 64'(busy_vec), 64'd0);
        check("rst12 sb_err", 64'(sb_err), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst12 stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        do_reset("rst12");
        md_done = 1; md_done_rd = 5'd12;
        tick("md12_late");
        check("md12 late sb_err", 64'(sb_err), 64'd1);

        // Randomized traffic against the model.
        do_reset("rand");
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) rs_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
            rs_used     = 2'($urandom);
            ex_wr_en    = ($urandom_range(0, 3) != 0);
            ex_wr_addr  = 5'($urandom_range(0, 7));
            ex_m2r      = 2'($urandom);
            wb_wr_en    = ($urandom_range(0, 3) != 0);
            wb_wr_addr  = 5'($urandom_range(0, 7));
            wb_m2r      = 2'($urandom);
            id_wr_en    = $urandom_range(0, 1);
            id_wr_addr  = 5'($urandom_range(0, 7));
            md_issue    = ($urandom_range(0, 3) == 0);
            md_issue_rd = 5'($urandom_range(0, 7));
            md_done     = ($urandom_range(0, 4) == 0);
            md_done_rd  = 5'($urandom_range(0, 7));
            tick($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
